// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed program over 8N1 UART and writes it into instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before the core is released.
module program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]   CAP      = 32'd1 << ADDR_WIDTH;

    // ---------------- UART receive ----------------
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t     rx_state;
    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    rx_byte;
    logic          byte_valid;
    logic          frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= R_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= uart_rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= R_START;
                        cnt      <= '0;
                    end
                end
                R_START: begin
                    if (cnt == HALF_CNT) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        // A start bit that is high again at mid-bit was a glitch
                        rx_state <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == FULL_CNT) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) rx_state <= R_STOP;
                        else                 bit_idx  <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt == FULL_CNT) begin
                        cnt      <= '0;
                        rx_state <= R_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- Load protocol ----------------
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {RX_LEN, RX_DATA, CHK, DONE, ERR} state_t;
    localparam state_t AFTER_LOAD = CHK;
`else
    typedef enum logic [2:0] {RX_LEN, RX_DATA, DONE, ERR} state_t;
    localparam state_t AFTER_LOAD = DONE;
`endif

    state_t                state;
    logic [1:0]            byte_cnt;
    logic [23:0]           len_sh;
    logic [23:0]           word_sh;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [31:0]           len_next;
    logic [31:0]           word_next;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    // Bytes arrive LSB-first, so each new byte enters at the top and shifts down
    assign len_next  = {rx_byte, len_sh};
    assign word_next = {rx_byte, word_sh};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RX_LEN;
            byte_cnt   <= '0;
            len_sh     <= '0;
            word_sh    <= '0;
            last_idx   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                RX_LEN: begin
                    if (frame_err) begin
                        state <= ERR;
                        error <= 1'b1;
                    end else if (byte_valid) begin
                        len_sh   <= len_next[31:8];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (len_next > CAP) begin
                                state <= ERR;
                                error <= 1'b1;
                            end else if (len_next == 32'd0) begin
                                state <= AFTER_LOAD;
`ifndef LOADER_CHECKSUM_EN
                                busy  <= 1'b0;
                                done  <= 1'b1;
`endif
                            end else begin
                                state    <= RX_DATA;
                                last_idx <= ADDR_WIDTH'(len_next - 32'd1);
                            end
                        end
                    end
                end
                RX_DATA: begin
                    if (frame_err) begin
                        state <= ERR;
                        error <= 1'b1;
                    end else begin
                        if (byte_valid) begin
                            word_sh  <= word_next[31:8];
                            byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                            csum     <= csum ^ rx_byte;
`endif
                            if (byte_cnt == 2'd3) begin
                                imem_wdata <= word_next;
                                imem_we    <= 1'b1;
                            end
                        end
                        // Address advances after its strobe; the last index is held, never wrapped
                        if (imem_we) begin
                            if (imem_addr == last_idx) begin
                                state <= AFTER_LOAD;
`ifndef LOADER_CHECKSUM_EN
                                busy  <= 1'b0;
                                done  <= 1'b1;
`endif
                            end else begin
                                imem_addr <= imem_addr + 1'b1;
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (frame_err) begin
                        state <= ERR;
                        error <= 1'b1;
                    end else if (byte_valid) begin
                        if (rx_byte == csum) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                DONE:    state <= DONE;
                ERR:     state <= ERR;
                default: state <= ERR;
            endcase
        end
    end

endmodule
